// File: rtl/ring_meas_pkg.sv
// Shared definitions for the ring oscillator frequency meter: FSM state
// encoding, fixed phase lengths and the gate window decode.
package ring_meas_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ARM   = 3'd2,
    GATE  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } meas_state_t;

  // Cycles the osc-domain logic is held in clear before arming
  localparam int CLEAR_LEN = 4;
  // Extra clk cycles after gate_ack falls, so the counter is quiet before capture
  localparam int DRAIN_SETTLE = 2;
  // Width of the clk-domain phase counter (covers 2048-cycle window and timeouts)
  localparam int PHASE_W = 16;

  // Gate window length in clk cycles: 2^(sel+4)
  function automatic logic [PHASE_W-1:0] gate_window(input logic [2:0] sel);
    return 16'd16 << sel;
  endfunction

endpackage

// File: rtl/osc_edge_counter.sv
// Oscillator-domain half of the meter: synchronises the gate enable onto
// osc_in, counts rising edges while it is set and remembers any wrap.
module osc_edge_counter #(
  parameter int CNT_W = 20
) (
  input  logic             osc_in,
  input  logic             clr,
  input  logic             gate_en,
  output logic             en_sync,
  output logic [CNT_W-1:0] count,
  output logic             wrapped
);

  logic             en_s1_reg;
  logic             en_s2_reg;
  logic [CNT_W-1:0] count_reg;
  logic             wrap_reg;

  // Enable synchroniser, edge counter and sticky wrap flag, cleared asynchronously from clk domain
  always_ff @(posedge osc_in or posedge clr) begin
    if (clr) begin
      en_s1_reg <= 1'b0;
      en_s2_reg <= 1'b0;
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      en_s1_reg <= gate_en;
      en_s2_reg <= en_s1_reg;
      if (en_s2_reg) begin
        count_reg <= count_reg + 1'b1;
        if (&count_reg) begin
          wrap_reg <= 1'b1;
        end
      end
    end
  end

  assign en_sync = en_s2_reg;
  assign count   = count_reg;
  assign wrapped = wrap_reg;

endmodule

// File: rtl/ring_freq_meter.sv
// Ring oscillator frequency meter: enables the ring, opens a gate window of
// 2^(gate_sel+4) clk cycles, counts osc_in edges in the osc domain and
// captures the count once the osc domain has acknowledged gate close.
module ring_freq_meter
  import ring_meas_pkg::*;
#(
  parameter int CNT_W    = 20,
  parameter int SETTLE   = 16,
  parameter int DRAIN_TO = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             osc_in,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  output logic             ring_ena,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             overflow,
  output logic             timeout
);

  meas_state_t          state_reg, state_next;
  logic [PHASE_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]           gsel_reg, gsel_next;
  logic                 ack_seen_reg, ack_seen_next;
  logic                 drain_ok_reg, drain_ok_next;
  logic [1:0]           settle_reg, settle_next;
  logic                 ring_ena_reg, ring_ena_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic [CNT_W-1:0]     result_reg, result_next;
  logic                 overflow_reg, overflow_next;
  logic                 timeout_reg, timeout_next;
  logic                 osc_clr_reg, osc_clr_next;
  logic                 gate_en_reg, gate_en_next;
  logic                 ack_s1_reg, ack_s2_reg;

  logic                 osc_clr;
  logic                 en_sync;
  logic [CNT_W-1:0]     osc_count;
  logic                 osc_wrapped;
  logic                 gate_ack;

  // Reset also clears the osc-domain logic, which has no rst_n of its own
  assign osc_clr  = osc_clr_reg | ~rst_n;
  assign gate_ack = ack_s2_reg;

  osc_edge_counter #(.CNT_W(CNT_W)) u_counter (
    .osc_in  (osc_in),
    .clr     (osc_clr),
    .gate_en (gate_en_reg),
    .en_sync (en_sync),
    .count   (osc_count),
    .wrapped (osc_wrapped)
  );

  // Bring the osc-domain enable back to clk as gate_ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_s1_reg <= 1'b0;
      ack_s2_reg <= 1'b0;
    end else begin
      ack_s1_reg <= en_sync;
      ack_s2_reg <= ack_s1_reg;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      gsel_reg     <= '0;
      ack_seen_reg <= 1'b0;
      drain_ok_reg <= 1'b0;
      settle_reg   <= '0;
      ring_ena_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      timeout_reg  <= 1'b0;
      osc_clr_reg  <= 1'b0;
      gate_en_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      gsel_reg     <= gsel_next;
      ack_seen_reg <= ack_seen_next;
      drain_ok_reg <= drain_ok_next;
      settle_reg   <= settle_next;
      ring_ena_reg <= ring_ena_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
      timeout_reg  <= timeout_next;
      osc_clr_reg  <= osc_clr_next;
      gate_en_reg  <= gate_en_next;
    end
  end

  // Next-state and output decode; outputs are derived from the next state so they register glitch-free
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    gsel_next     = gsel_reg;
    // A dead oscillator never raises gate_ack, so DRAIN only treats ack=0 as
    // "closed" once it has seen the ack go high during this measurement.
    ack_seen_next = ack_seen_reg | (gate_ack & ((state_reg == GATE) | (state_reg == DRAIN)));
    drain_ok_next = drain_ok_reg;
    settle_next   = settle_reg;
    result_next   = result_reg;
    overflow_next = overflow_reg;
    timeout_next  = timeout_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CLEAR;
          gsel_next  = gate_sel;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        ack_seen_next = 1'b0;
        drain_ok_next = 1'b0;
        settle_next   = '0;
        if (cnt_reg == PHASE_W'(CLEAR_LEN - 1)) begin
          state_next = ARM;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ARM: begin
        if (cnt_reg == PHASE_W'(SETTLE - 1)) begin
          state_next = GATE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GATE: begin
        if (cnt_reg == gate_window(gsel_reg) - 1'b1) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_ok_reg) begin
          if (settle_reg == 2'(DRAIN_SETTLE - 1)) begin
            state_next    = DONE;
            result_next   = osc_count;
            overflow_next = osc_wrapped;
            timeout_next  = 1'b0;
          end else begin
            settle_next = settle_reg + 1'b1;
          end
        end else if (ack_seen_reg && !gate_ack) begin
          drain_ok_next = 1'b1;
        end else if (cnt_reg == PHASE_W'(DRAIN_TO - 1)) begin
          state_next    = DONE;
          result_next   = osc_count;
          overflow_next = osc_wrapped;
          timeout_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    ring_ena_next = (state_next == ARM) | (state_next == GATE) | (state_next == DRAIN);
    busy_next     = (state_next != IDLE);
    done_next     = (state_next == DONE);
    osc_clr_next  = (state_next == CLEAR);
    gate_en_next  = (state_next == GATE);
  end

  assign ring_ena = ring_ena_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign result   = result_reg;
  assign overflow = overflow_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_ring_freq_meter.sv
// Directed and randomised checks of ring_freq_meter against an arithmetic
// model: expected count = f_osc * window / f_clk, within +/-2 counts.
module tb_ring_freq_meter;

  localparam int CLK_HALF  = 10000;   // 50 MHz clk, delays in ps-scale units
  localparam int SETTLE    = 16;
  localparam int DRAIN_TO  = 255;
  localparam int CLEAR_LEN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        osc_in;
  logic        start;
  logic        start8;
  logic [2:0]  gate_sel;

  logic        ring_ena, busy, done, overflow, timeout;
  logic [19:0] result;
  logic        ring_ena8, busy8, done8, overflow8, timeout8;
  logic [7:0]  result8;

  int osc_half  = 2500;
  bit osc_alive = 1'b1;

  int checks   = 0;
  int failures = 0;

  // Per-measurement observations
  int     m_busy, m_ring, m_pre_low, m_done_pulses, m_ring_at_done, m_seen;
  longint m_result;
  int     m_ovf, m_to;

  ring_freq_meter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .osc_in   (osc_in),
    .start    (start),
    .gate_sel (gate_sel),
    .ring_ena (ring_ena),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .timeout  (timeout)
  );

  ring_freq_meter #(.CNT_W(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .osc_in   (osc_in),
    .start    (start8),
    .gate_sel (gate_sel),
    .ring_ena (ring_ena8),
    .busy     (busy8),
    .done     (done8),
    .result   (result8),
    .overflow (overflow8),
    .timeout  (timeout8)
  );

  always #CLK_HALF clk = ~clk;

  initial begin
    osc_in = 1'b0;
    forever begin
      #(osc_half);
      if (osc_alive) osc_in = ~osc_in;
      else           osc_in = 1'b0;
    end
  end

  task automatic chk_eq(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
    checks++;
    assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Ideal edge count: window * clk period / osc period
  function automatic real exp_count(input int half, input logic [2:0] sel);
    return real'(16 << sel) * real'(2 * CLK_HALF) / real'(2 * half);
  endfunction

  task automatic chk_count(input string tag, input longint obs, input real e);
    chk_rng(tag, obs, longint'($ceil(e - 2.0)), longint'($floor(e + 2.0)));
  endtask

  // Caller is at a negedge; start is presented for exactly the next posedge
  task automatic run_meas(input bit use8, input logic [2:0] sel, input int inject_at);
    bit b, d, r, ena_started;
    m_busy = 0; m_ring = 0; m_pre_low = 0; m_done_pulses = 0;
    m_ring_at_done = 0; m_seen = 0; m_result = 0; m_ovf = 0; m_to = 0;
    ena_started = 1'b0;
    gate_sel = sel;
    if (use8) start8 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start8 = 1'b0;
    for (int i = 0; i < 6000 && m_seen == 0; i++) begin
      b = use8 ? busy8 : busy;
      d = use8 ? done8 : done;
      r = use8 ? ring_ena8 : ring_ena;
      start = (i == inject_at);
      if (b) m_busy++;
      if (r) m_ring++;
      if (b && !r && !ena_started) m_pre_low++;
      if (r) ena_started = 1'b1;
      if (d) begin
        m_seen = 1;
        m_done_pulses++;
        m_ring_at_done = int'(r);
        m_result = use8 ? longint'(result8) : longint'(result);
        m_ovf = int'(use8 ? overflow8 : overflow);
        m_to  = int'(use8 ? timeout8 : timeout);
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (use8 ? done8 : done) m_done_pulses++;
      @(negedge clk);
    end
    chk_eq("done_seen", m_seen, 1);
  endtask

  initial begin
    real e;
    int  diff;
    logic [2:0] rsel;
    rst_n = 1'b0; start = 1'b0; start8 = 1'b0; gate_sel = 3'd0;

    // Reset values
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_ring_ena", ring_ena, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_result", result, 0);
    chk_eq("rst_overflow", overflow, 0);
    chk_eq("rst_timeout", timeout, 0);
    chk_eq("rst_busy8", busy8, 0);

    // 200 MHz, gate_sel=0; start on the first edge after reset release
    @(negedge clk);
    rst_n = 1'b1;
    osc_half = 2500;
    run_meas(1'b0, 3'd0, -1);
    $display("meas f=200MHz sel=0 result=%0d ovf=%0d to=%0d busy=%0d", m_result, m_ovf, m_to, m_busy);
    chk_count("r200_result", m_result, exp_count(2500, 3'd0));
    chk_eq("r200_overflow", m_ovf, 0);
    chk_eq("r200_timeout", m_to, 0);
    chk_eq("r200_clear_len", m_pre_low, CLEAR_LEN);
    chk_eq("r200_done_pulses", m_done_pulses, 1);

    // 10 MHz, gate_sel=7; ring_ena spans ARM..DRAIN only
    osc_half = 50000;
    run_meas(1'b0, 3'd7, -1);
    $display("meas f=10MHz sel=7 result=%0d ovf=%0d to=%0d busy=%0d ring=%0d", m_result, m_ovf, m_to, m_busy, m_ring);
    chk_count("r10_result", m_result, exp_count(50000, 3'd7));
    chk_eq("r10_ring_pre_low", m_pre_low, CLEAR_LEN);
    chk_eq("r10_ring_cycles", m_ring, m_busy - CLEAR_LEN - 1);
    chk_eq("r10_ring_at_done", m_ring_at_done, 0);
    chk_eq("r10_overflow", m_ovf, 0);

    // Reset pulsed during GATE
    osc_half = 2500;
    gate_sel = 3'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (CLEAR_LEN + SETTLE + 40) @(negedge clk);
    chk_eq("midrst_ring_before", ring_ena, 1);
    #(CLK_HALF / 2);
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_ring_ena", ring_ena, 0);
    chk_eq("midrst_done", done, 0);
    chk_eq("midrst_result", result, 0);
    chk_eq("midrst_overflow", overflow, 0);
    chk_eq("midrst_timeout", timeout, 0);
    $display("reset during gate busy=%0d ring_ena=%0d result=%0d", busy, ring_ena, result);
    @(negedge clk);
    rst_n = 1'b1;
    run_meas(1'b0, 3'd0, -1);
    $display("meas after reset f=200MHz sel=0 result=%0d", m_result);
    chk_count("postrst_result", m_result, exp_count(2500, 3'd0));
    chk_eq("postrst_timeout", m_to, 0);

    // start re-asserted during GATE is ignored
    run_meas(1'b0, 3'd0, CLEAR_LEN + SETTLE + 5);
    $display("meas restart-in-gate result=%0d done_pulses=%0d", m_result, m_done_pulses);
    chk_eq("restart_done_pulses", m_done_pulses, 1);
    chk_count("restart_result", m_result, exp_count(2500, 3'd0));

    // 8-bit counter wraps: 512 edges
    run_meas(1'b1, 3'd3, -1);
    e = exp_count(2500, 3'd3);
    diff = int'(m_result) - (int'(e) % 256);
    if (diff > 127) diff -= 256;
    if (diff < -128) diff += 256;
    $display("meas cnt8 f=200MHz sel=3 result=%0d ovf=%0d", m_result, m_ovf);
    chk_eq("wrap_overflow", m_ovf, 1);
    chk_rng("wrap_result_moddiff", diff, -2, 2);
    chk_eq("wrap_timeout", m_to, 0);

    // Dead oscillator: timeout after DRAIN_TO cycles
    osc_alive = 1'b0;
    run_meas(1'b0, 3'd0, -1);
    $display("meas dead osc result=%0d to=%0d busy=%0d", m_result, m_to, m_busy);
    chk_eq("dead_timeout", m_to, 1);
    chk_eq("dead_result", m_result, 0);
    chk_eq("dead_busy_cycles", m_busy, CLEAR_LEN + SETTLE + 16 + DRAIN_TO + 1);
    osc_alive = 1'b1;

    // Randomised frequencies and windows
    for (int n = 0; n < 6; n++) begin
      osc_half = int'($urandom_range(2000, 40000));
      rsel = 3'($urandom_range(0, 7));
      run_meas(1'b0, rsel, -1);
      e = exp_count(osc_half, rsel);
      $display("meas rand half=%0d sel=%0d result=%0d model=%0.2f", osc_half, rsel, m_result, e);
      chk_count("rand_result", m_result, e);
      chk_eq("rand_overflow", m_ovf, (e >= 1048576.0) ? 1 : 0);
      chk_eq("rand_timeout", m_to, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_freq_meter.md
RING_FREQ_METER -- requirements
Module: ring_freq_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 20, meaning the width of the oscillator-edge counter and of the result.
REQ-002 SHALL have parameter SETTLE, default 16, meaning the clk cycles allowed for ring start-up before gating begins.
REQ-003 SHALL have parameter DRAIN_TO, default 255, meaning the maximum clk cycles spent waiting for the oscillator domain to acknowledge gate close.
REQ-004 SHALL have port clk  in  1  system clock; the block uses one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port osc_in  in  1  ring oscillator output, asynchronous to clk, frequency unrelated to clk.
REQ-007 SHALL have port start  in  1  single-cycle request to begin one measurement.
REQ-008 SHALL have port gate_sel  in  3  gate window select; window = 2^(gate_sel+4) clk cycles (16..2048).
REQ-009 SHALL have port ring_ena  out  1  enable to the ring oscillator under test.
REQ-010 SHALL have port busy  out  1  high while a measurement is in progress.
REQ-011 SHALL have port done  out  1  single-cycle pulse when result is updated.
REQ-012 SHALL have port result  out  CNT_W  osc_in rising edges counted within the gate window.
REQ-013 SHALL have port overflow  out  1  the counter wrapped during the last measurement.
REQ-014 SHALL have port timeout  out  1  the last measurement ended by DRAIN timeout (dead oscillator).

Function
REQ-015 SHALL implement the FSM states IDLE, CLEAR, ARM, GATE, DRAIN, DONE.
REQ-016 SHALL in IDLE move to CLEAR on start=1, latching gate_sel; start SHALL be ignored in all other states.
REQ-017 SHALL in CLEAR hold the osc-domain counter, its overflow bit and its sync flops in asynchronous clear for 4 clk cycles, then move to ARM.
REQ-018 SHALL in ARM release the clear, drive ring_ena=1, and wait SETTLE clk cycles before moving to GATE.
REQ-019 SHALL in GATE drive gate_en=1 for exactly the latched window length, then move to DRAIN.
REQ-020 SHALL synchronise gate_en into the osc_in domain with 2 flops clocked by osc_in rising edge, with the counter incrementing only on edges where the synchronised enable is 1.
REQ-021 SHALL return the synchronised enable to clk as gate_ack through a 2-flop synchroniser.
REQ-022 SHALL in DRAIN wait for gate_ack=0 and then 2 further clk cycles before moving to DONE.
REQ-023 SHALL also exit DRAIN to DONE with timeout=1 if DRAIN_TO clk cycles elapse without gate_ack=0.
REQ-024 SHALL in DONE capture the static counter into result, set overflow and timeout, pulse done for 1 cycle, and return to IDLE.
REQ-025 SHALL wrap the counter modulo 2^CNT_W, with a sticky osc-domain bit recording any wrap; that bit SHALL be captured into overflow in DONE.
REQ-026 SHALL hold ring_ena=1 from ARM through DRAIN and drive ring_ena=0 in IDLE, CLEAR and DONE.
REQ-027 SHALL drive busy=1 in every state except IDLE.
REQ-028 SHALL hold result, overflow and timeout stable from DONE until the next DONE.
REQ-029 SHALL produce a result within +/-2 counts of f_osc*window/f_clk when the oscillator is running.

Reset
REQ-030 SHALL on rst_n=0, at any time including mid-measurement, asynchronously force state=IDLE, ring_ena=0, busy=0, done=0, result=0, overflow=0, timeout=0, and clear the osc-domain counter, its overflow bit and its sync flops.
REQ-031 SHALL accept start on the first clk edge after rst_n deasserts.

Structure
REQ-032 SHALL place the FSM state encoding, the CLEAR length (4) and the DRAIN settle constant (2) in shared package ring_meas_pkg.
REQ-033 SHALL contain one sub-module, osc_edge_counter, holding the osc_in-clocked enable synchroniser, counter and sticky wrap bit.

Verification
REQ-034 SHALL cover: clk 50 MHz, osc 200 MHz, gate_sel=0, start -> done after about 16+4+16+drain cycles, result 64+/-2, overflow=0, timeout=0.
REQ-035 SHALL cover: clk 50 MHz, osc 10 MHz, gate_sel=7 -> result 409+/-2 and ring_ena high only from ARM to DRAIN.
REQ-036 SHALL cover: osc_in held at 0, start -> timeout=1 and result=0 after DRAIN_TO cycles, then done.
REQ-037 SHALL cover: CNT_W=8, osc 200 MHz, gate_sel=3 -> overflow=1 and result=(512 mod 256)+/-2.
REQ-038 SHALL cover: rst_n pulsed low during GATE -> all outputs 0 immediately, with the next start giving a correct result.
REQ-039 SHALL cover: start reasserted during GATE -> ignored and exactly one done pulse produced.
